// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared owner encoding, default width and read-tag type for the VRAM arbiter
package vram_pkg;

    localparam int DEF_AW = 13;

    localparam logic OWN_CPU = 1'b1;
    localparam logic OWN_VID = 1'b0;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// rtl/vram_rd_tag_pipe.sv - READ_LAT+1 stage tag shift register steering RAM read data to its requester
module vram_rd_tag_pipe
    import vram_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic issue_valid,
    input  logic issue_owner,
    output logic cpu_sel,
    output logic vid_sel
);

    tag_t [READ_LAT:0] stage;

    // The last stage lines up with the cycle in which ram_dout carries the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage[0] <= '{valid: issue_valid, owner: issue_owner};
            for (int i = 1; i <= READ_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    always_comb begin
        cpu_sel = stage[READ_LAT].valid & (stage[READ_LAT].owner == OWN_CPU);
        vid_sel = stage[READ_LAT].valid & (stage[READ_LAT].owner == OWN_VID);
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - CPU/video arbiter for the single-port VRAM; VRAM_ARB_POSTED_WRITE_EN adds a posted CPU write buffer
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int READ_LAT  = 1,
    parameter int MAX_STALL = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_wait,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_valid,
    output logic [7:0]    vid_rdata,
    output logic [AW-1:0] ram_ad,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout,
    output logic          ram_ce,
    output logic          ram_wre,
    output logic          ram_oce,
    output logic          ram_reset
);

    logic          cpu_src;
    logic          src_we;
    logic          src_buf;
    logic [AW-1:0] src_addr;
    logic [7:0]    src_data;
    logic          posted_ack;
    logic          cpu_gnt;
    logic          cpu_busy;
    logic [3:0]    stall_cnt;
    logic          wr_ack_q;
    logic          rd_ack_q;
    logic          rd_cpu_sel;
    logic          rd_vid_sel;

`ifdef VRAM_ARB_POSTED_WRITE_EN
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [7:0]    wb_data;

    // A full buffer is the CPU source; anything new from the CPU waits behind it.
    always_comb begin
        posted_ack = cpu_req & cpu_we & ~wb_valid;
        src_buf    = wb_valid;
        cpu_src    = wb_valid | (cpu_req & ~cpu_we & ~cpu_busy);
        src_we     = wb_valid;
        src_addr   = wb_valid ? wb_addr : cpu_addr;
        src_data   = wb_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (posted_ack) begin
            wb_valid <= 1'b1;
            wb_addr  <= cpu_addr;
            wb_data  <= cpu_wdata;
        end else if (cpu_gnt && wb_valid) begin
            wb_valid <= 1'b0;
        end
    end
`else
    always_comb begin
        posted_ack = 1'b0;
        src_buf    = 1'b0;
        cpu_src    = cpu_req & ~cpu_busy;
        src_we     = cpu_we;
        src_addr   = cpu_addr;
        src_data   = cpu_wdata;
    end
`endif

    always_comb begin
        cpu_gnt = cpu_src & (~vid_req | (stall_cnt == 4'(MAX_STALL)));
        vid_gnt = vid_req & ~cpu_gnt;
    end

    assign cpu_ack   = wr_ack_q | rd_ack_q | posted_ack;
    assign cpu_wait  = cpu_req & ~cpu_ack;
    assign ram_oce   = 1'b1;
    assign ram_reset = ~reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            cpu_busy  <= 1'b0;
        end else begin
            if (cpu_gnt || !cpu_src) begin
                stall_cnt <= '0;
            end else if (vid_gnt) begin
                stall_cnt <= stall_cnt + 4'd1;
            end
            // Busy spans grant through the ack cycle so a held request is not re-issued.
            if (cpu_ack) begin
                cpu_busy <= 1'b0;
            end else if (cpu_gnt && !src_buf) begin
                cpu_busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_ce   <= 1'b0;
            ram_wre  <= 1'b0;
            ram_ad   <= '0;
            ram_din  <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            ram_ce   <= cpu_gnt | vid_gnt;
            ram_wre  <= cpu_gnt & src_we;
            wr_ack_q <= cpu_gnt & src_we & ~src_buf;
            if (cpu_gnt) begin
                ram_ad <= src_addr;
                if (src_we) begin
                    ram_din <= src_data;
                end
            end else if (vid_gnt) begin
                ram_ad <= vid_addr;
            end
        end
    end

    vram_rd_tag_pipe #(
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid ((cpu_gnt & ~src_we) | vid_gnt),
        .issue_owner (cpu_gnt ? OWN_CPU : OWN_VID),
        .cpu_sel     (rd_cpu_sel),
        .vid_sel     (rd_vid_sel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ack_q  <= 1'b0;
            vid_valid <= 1'b0;
            cpu_rdata <= '0;
            vid_rdata <= '0;
        end else begin
            rd_ack_q  <= rd_cpu_sel;
            vid_valid <= rd_vid_sel;
            if (rd_cpu_sel) begin
                cpu_rdata <= ram_dout;
            end
            if (rd_vid_sel) begin
                vid_rdata <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed vector bench for vram_arbiter with a behavioural RAM model
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int RL = 1;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          cpu_wait;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_gnt;
    logic          vid_valid;
    logic [7:0]    vid_rdata;
    logic [AW-1:0] ram_ad;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;
    logic          ram_ce;
    logic          ram_wre;
    logic          ram_oce;
    logic          ram_reset;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW        (AW),
        .READ_LAT  (RL),
        .MAX_STALL (MS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_wait  (cpu_wait),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_gnt   (vid_gnt),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_ce    (ram_ce),
        .ram_wre   (ram_wre),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset)
    );

    // RAM model: contents preloaded while reset is low, RL-cycle read pipeline.
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] q1, q2, q3;
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[13'h0100] <= 8'h5A;
            mem[13'h0020] <= 8'h77;
            mem[13'h0030] <= 8'h3C;
            for (int i = 0; i < 8; i++) mem[i] <= 8'hC0 + 8'(i);
        end else if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         q1 <= mem[ram_ad];
        end
        q2 <= q1;
        q3 <= q2;
    end
    assign ram_dout = (RL == 1) ? q1 : (RL == 2) ? q2 : q3;

    typedef struct {
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [7:0]    cwd;
        logic [26:0]   exp;
        logic          chk_rd;
        logic [7:0]    exp_rd;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [7:0] cwd, input logic ack, input logic wt, input logic ce,
                       input logic wre, input logic [AW-1:0] ad, input logic [7:0] din,
                       input logic chk_rd, input logic [7:0] exp_rd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.exp = {ack, wt, 1'b0, 1'b0, ce, wre, ad, din};
        v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] exp, input int exp_lat,
                           input string nm);
        int lat = -1;
        logic [7:0] rd = '0;
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        for (int k = 0; k < 16; k++) begin
            #2;
            if (cpu_ack) begin
                lat = k; rd = cpu_rdata;
                break;
            end
            next_cycle();
        end
        next_cycle();
        cpu_req = 1'b0;
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_data"}, 64'(rd), 64'(exp));
    endtask

    initial begin
        int ack_seen;
        int ack_k;
        logic [7:0] ack_d;

        #3;
        chk("reset_state", {ram_ce, ram_wre, ram_reset, ram_oce, cpu_ack, vid_valid, vid_gnt, ram_ad},
            {7'b0011000, 13'h0});
        repeat (3) next_cycle();
        reset_n = 1'b1;
        repeat (2) next_cycle();

        // CPU read of 0x0100
        add(1,0,13'h0100,8'h00, 0,1,0,0,13'h0000,8'h00, 0,8'h00);
        add(1,0,13'h0100,8'h00, 0,1,1,0,13'h0100,8'h00, 0,8'h00);
        add(1,0,13'h0100,8'h00, 0,1,0,0,13'h0100,8'h00, 0,8'h00);
        add(1,0,13'h0100,8'h00, 1,0,0,0,13'h0100,8'h00, 1,8'h5A);
        add(0,0,13'h0100,8'h00, 0,0,0,0,13'h0100,8'h00, 0,8'h00);
`ifdef VRAM_ARB_POSTED_WRITE_EN
        add(1,1,13'h1FFF,8'hA5, 1,0,0,0,13'h0100,8'h00, 0,8'h00);
        add(0,0,13'h1FFF,8'hA5, 0,0,0,0,13'h0100,8'h00, 0,8'h00);
        add(0,0,13'h1FFF,8'hA5, 0,0,1,1,13'h1FFF,8'hA5, 0,8'h00);
        add(0,0,13'h1FFF,8'hA5, 0,0,0,0,13'h1FFF,8'hA5, 0,8'h00);
`else
        add(1,1,13'h1FFF,8'hA5, 0,1,0,0,13'h0100,8'h00, 0,8'h00);
        add(1,1,13'h1FFF,8'hA5, 1,0,1,1,13'h1FFF,8'hA5, 0,8'h00);
        add(0,0,13'h1FFF,8'hA5, 0,0,0,0,13'h1FFF,8'hA5, 0,8'h00);
        add(0,0,13'h1FFF,8'hA5, 0,0,0,0,13'h1FFF,8'hA5, 0,8'h00);
`endif
        // readback of 0x1FFF
        add(1,0,13'h1FFF,8'h00, 0,1,0,0,13'h1FFF,8'hA5, 0,8'h00);
        add(1,0,13'h1FFF,8'h00, 0,1,1,0,13'h1FFF,8'hA5, 0,8'h00);
        add(1,0,13'h1FFF,8'h00, 0,1,0,0,13'h1FFF,8'hA5, 0,8'h00);
        add(1,0,13'h1FFF,8'h00, 1,0,0,0,13'h1FFF,8'hA5, 1,8'hA5);
        add(0,0,13'h1FFF,8'h00, 0,0,0,0,13'h1FFF,8'hA5, 0,8'h00);

        for (int i = 0; i < vt.size(); i++) begin
            next_cycle();
            cpu_req = vt[i].creq; cpu_we = vt[i].cwe;
            cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwd;
            #2;
            chk($sformatf("vec%0d", i),
                64'({cpu_ack, cpu_wait, vid_gnt, vid_valid, ram_ce, ram_wre, ram_ad, ram_din}),
                64'(vt[i].exp));
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 64'(cpu_rdata), 64'(vt[i].exp_rd));
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (3) next_cycle();

        // Video held high with a CPU read pending: CPU forced through after MS losses
        ack_k = -1; ack_d = '0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) next_cycle();
            vid_req = 1'b1; vid_addr = 13'h0020;
            if (k == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0030; end
            if (ack_k >= 0) cpu_req = 1'b0;
            #2;
            if (k <= MS + 1) chk($sformatf("stall_vgnt%0d", k), 64'(vid_gnt), 64'(k != MS));
            if (vid_valid) chk($sformatf("stall_vdata%0d", k), 64'(vid_rdata), 64'h77);
            if (cpu_ack && ack_k < 0) begin ack_k = k; ack_d = cpu_rdata; end
        end
        chk("stall_ack_cycle", 64'(ack_k), 64'(MS + 2 + RL));
        chk("stall_ack_data", 64'(ack_d), 64'h3C);
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (4) next_cycle();

        // Video burst 0x4000.. truncated to AW bits
        for (int k = 0; k < 8 + RL + 5; k++) begin
            next_cycle();
            vid_req = (k < 8);
            vid_addr = AW'(32'h4000 + k);
            #2;
            chk($sformatf("burst_gnt%0d", k), 64'(vid_gnt), 64'(k < 8));
            chk($sformatf("burst_valid%0d", k), 64'(vid_valid),
                64'((k >= 2 + RL) && (k < 10 + RL)));
            if ((k >= 2 + RL) && (k < 10 + RL))
                chk($sformatf("burst_data%0d", k), 64'(vid_rdata), 64'(8'hC0 + 8'(k - 2 - RL)));
        end
        vid_req = 1'b0;
        repeat (2) next_cycle();

        // Reset in G+1 of a CPU read
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        next_cycle();
        reset_n = 1'b0; cpu_req = 1'b0;
        #1;
        chk("midreset_out", {ram_ce, ram_reset, ram_oce, cpu_ack, ram_ad}, {4'b0110, 13'h0});
        repeat (2) next_cycle();
        reset_n = 1'b1;
        ack_seen = 0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            #2;
            if (cpu_ack || vid_valid) ack_seen++;
        end
        chk("midreset_no_ack", 64'(ack_seen), 64'd0);
        do_read(13'h0100, 8'h5A, 2 + RL, "post_reset_read");
        repeat (2) next_cycle();

`ifdef VRAM_ARB_POSTED_WRITE_EN
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h33;
        #2;
        chk("posted_ack", {cpu_ack, cpu_wait}, 2'b10);
        do_read(13'h0010, 8'h33, 3 + RL, "raw_read");
`else
        do_read(13'h0030, 8'h3C, 2 + RL, "plain_read");
`endif
        repeat (2) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
